// File: rtl/ps2_key_event_queue_if.sv
// Byte-in / event-out bundle for ps2_key_event_queue.
// The slave modport is the queue itself; the master side feeds bytes and consumes events.
interface ps2_key_event_queue_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [13:0]   evt_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_count;
  logic          overflow;
  logic          caps_lock;

  modport slave (
    input  rx_data, rx_valid, evt_ready,
    output evt_data, evt_valid, evt_count, overflow, caps_lock
  );

  modport master (
    output rx_data, rx_valid, evt_ready,
    input  evt_data, evt_valid, evt_count, overflow, caps_lock
  );
endinterface

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 decoder with modifier/caps tracking feeding a valid/ready event FIFO.
// Event word: {brk, ext, shift, ctrl, alt, caps, code[7:0]}.
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH   = 8,
  parameter bit REPORT_BREAK = 1'b0,
  parameter bit QUEUE_MODS   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_key_event_queue_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Held-bit order: lshift, rshift, lctrl, rctrl, lalt, ralt.
  localparam logic [47:0] MOD_CODES = {8'h11, 8'h11, 8'h14, 8'h14, 8'h59, 8'h12};
  localparam logic [5:0]  MOD_EXTS  = 6'b101000;

  typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_PAUSE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [5:0]    held_q, held_d;
  logic          caps_q, caps_d;
  logic          caps_held_q, caps_held_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [13:0]   mem_q [FIFO_DEPTH];

  logic          dec_evt, dec_brk, dec_ext;
  logic [7:0]    dec_code;
  logic [5:0]    mod_sel;
  logic          is_caps, is_mod, push_req, push, pop, full, empty;
  logic [13:0]   evt_word;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    dec_evt  = 1'b0;
    dec_brk  = 1'b0;
    dec_ext  = 1'b0;
    dec_code = bus.rx_data;
    if (bus.rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          case (bus.rx_data)
            8'hF0: state_d = S_BRK;
            8'hE0: state_d = S_EXT;
            8'hE1: begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
            default: dec_evt = 1'b1;
          endcase
        end
        S_BRK: begin
          dec_evt = 1'b1;
          dec_brk = 1'b1;
          state_d = S_IDLE;
        end
        S_EXT: begin
          if (bus.rx_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            // E0 12 is the fake shift some keyboards wrap around nav keys.
            dec_evt = (bus.rx_data != 8'h12);
            dec_ext = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          dec_evt = 1'b1;
          dec_brk = 1'b1;
          dec_ext = 1'b1;
          state_d = S_IDLE;
        end
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            dec_evt  = 1'b1;
            dec_code = 8'hE1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_mod
    assign mod_sel[gi] = (dec_code == MOD_CODES[gi*8 +: 8]) && (dec_ext == MOD_EXTS[gi]);
  end

  assign is_caps = (dec_code == 8'h58) && !dec_ext;
  assign is_mod  = (|mod_sel) || is_caps;

  always_comb begin
    held_d      = held_q;
    caps_held_d = caps_held_q;
    caps_d      = caps_q;
    if (dec_evt) begin
      for (int i = 0; i < 6; i++) begin
        if (mod_sel[i]) held_d[i] = !dec_brk;
      end
      if (is_caps) begin
        caps_held_d = !dec_brk;
        if (!dec_brk && !caps_held_q) caps_d = !caps_q;
      end
    end
  end

  // Modifiers are the pre-byte snapshot; caps is post-toggle so the key that flips it reports the new case.
  assign evt_word = {dec_brk, dec_ext, held_q[0] | held_q[1], held_q[2] | held_q[3],
                     held_q[4] | held_q[5], caps_d, dec_code};

  assign push_req = dec_evt && !(dec_brk && !REPORT_BREAK) && !(is_mod && !QUEUE_MODS);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = !empty && bus.evt_ready;
  assign push     = push_req && (!full || pop);

  always_comb begin
    wr_d       = push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop  ? rd_q + 1'b1 : rd_q;
    overflow_d = overflow_q || (push_req && full && !pop);
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      skip_q      <= '0;
      held_q      <= '0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      held_q      <= held_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      overflow_q  <= overflow_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
    end
  end

  // Storage is not reset; the empty flag masks stale contents on evt_data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= evt_word;
  end

  assign bus.evt_data  = empty ? '0 : mem_q[rd_q];
  assign bus.evt_valid = !empty;
  assign bus.evt_count = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.caps_lock = caps_q;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench: one default-parameter queue (a) and one REPORT_BREAK=1 queue (b) fed the same bytes.
module tb_ps2_key_event_queue;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_key_event_queue_if #(.FIFO_DEPTH(8)) bus_a ();
  ps2_key_event_queue_if #(.FIFO_DEPTH(8)) bus_b ();

  ps2_key_event_queue #(.FIFO_DEPTH(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  ps2_key_event_queue #(.FIFO_DEPTH(8), .REPORT_BREAK(1'b1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus_a.rx_data  = b;
    bus_b.rx_data  = b;
    bus_a.rx_valid = 1'b1;
    bus_b.rx_valid = 1'b1;
    @(negedge clk);
    bus_a.rx_valid = 1'b0;
    bus_b.rx_valid = 1'b0;
  endtask

  task automatic pop_both();
    @(negedge clk);
    bus_a.evt_ready = 1'b1;
    bus_b.evt_ready = 1'b1;
    @(negedge clk);
    bus_a.evt_ready = 1'b0;
    bus_b.evt_ready = 1'b0;
  endtask

  task automatic pop_b();
    @(negedge clk);
    bus_b.evt_ready = 1'b1;
    @(negedge clk);
    bus_b.evt_ready = 1'b0;
  endtask

  logic [7:0] fill [9];

  initial begin
    fill = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    bus_a.rx_data = '0; bus_a.rx_valid = 1'b0; bus_a.evt_ready = 1'b0;
    bus_b.rx_data = '0; bus_b.rx_valid = 1'b0; bus_b.evt_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus_a.evt_valid), 32'd0);
    chk("rst_count", 32'(bus_a.evt_count), 32'd0);
    chk("rst_ovf",   32'(bus_a.overflow),  32'd0);
    chk("rst_caps",  32'(bus_a.caps_lock), 32'd0);
    chk("rst_data",  32'(bus_a.evt_data),  32'd0);
    reset = 1'b1;

    // Plain make then break
    send(8'h1C); chk("t1_lat_valid", 32'(bus_a.evt_valid), 32'd1);
    send(8'hF0); send(8'h1C);
    chk("t1_a_count", 32'(bus_a.evt_count), 32'd1);
    chk("t1_a_head",  32'(bus_a.evt_data),  32'h01C);
    chk("t1_b_count", 32'(bus_b.evt_count), 32'd2);
    pop_both();
    chk("t1_a_empty", 32'(bus_a.evt_valid), 32'd0);
    chk("t1_b_brk",   32'(bus_b.evt_data),  32'h201C);
    pop_b();
    chk("t1_b_empty", 32'(bus_b.evt_count), 32'd0);

    // Shifted key, shift itself not queued
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("t2_a_count", 32'(bus_a.evt_count), 32'd1);
    chk("t2_a_head",  32'(bus_a.evt_data),  32'h081C);
    chk("t2_b_count", 32'(bus_b.evt_count), 32'd2);
    pop_both();
    chk("t2_b_brk",   32'(bus_b.evt_data),  32'h281C);
    pop_b();

    // Extended make/break and fake shift
    send(8'hE0); send(8'h74); send(8'hE0); send(8'hF0); send(8'h74);
    chk("t3_a_count", 32'(bus_a.evt_count), 32'd1);
    chk("t3_b_head",  32'(bus_b.evt_data),  32'h1074);
    pop_both();
    chk("t3_b_brk",   32'(bus_b.evt_data),  32'h3074);
    pop_b();
    send(8'hE0); send(8'h12);
    chk("t3_fake_a",  32'(bus_a.evt_count), 32'd0);
    chk("t3_fake_b",  32'(bus_b.evt_count), 32'd0);
    send(8'h1C);
    chk("t3_idle",    32'(bus_a.evt_data),  32'h01C);
    pop_both();

    // Caps lock toggle, typematic repeat and release
    send(8'h58);
    chk("t4_caps_on",  32'(bus_a.caps_lock), 32'd1);
    chk("t4_no_queue", 32'(bus_a.evt_count), 32'd0);
    send(8'h1C);
    chk("t4_caps_evt", 32'(bus_a.evt_data),  32'h11C);
    pop_both();
    send(8'h58); send(8'h58);
    chk("t4_repeat",   32'(bus_a.caps_lock), 32'd1);
    send(8'hF0); send(8'h58);
    chk("t4_release",  32'(bus_a.caps_lock), 32'd1);
    chk("t4_b_nobrk",  32'(bus_b.evt_count), 32'd0);
    send(8'h58);
    chk("t4_caps_off", 32'(bus_a.caps_lock), 32'd0);
    send(8'h1C);
    chk("t4_lower",    32'(bus_a.evt_data),  32'h01C);
    pop_both();

    // Overflow and push+pop on full
    for (int i = 0; i < 9; i++) send(fill[i]);
    chk("t5_count",  32'(bus_a.evt_count), 32'd8);
    chk("t5_ovf",    32'(bus_a.overflow),  32'd1);
    chk("t5_head",   32'(bus_a.evt_data),  32'h015);
    @(negedge clk);
    bus_a.rx_data = 8'h4D; bus_b.rx_data = 8'h4D;
    bus_a.rx_valid = 1'b1; bus_b.rx_valid = 1'b1;
    bus_a.evt_ready = 1'b1; bus_b.evt_ready = 1'b1;
    @(negedge clk);
    bus_a.rx_valid = 1'b0; bus_b.rx_valid = 1'b0;
    bus_a.evt_ready = 1'b0; bus_b.evt_ready = 1'b0;
    chk("t5_pp_count", 32'(bus_a.evt_count), 32'd8);
    chk("t5_pp_head",  32'(bus_a.evt_data),  32'h01D);
    for (int i = 0; i < 7; i++) pop_both();
    chk("t5_tail",     32'(bus_a.evt_data),  32'h04D);
    chk("t5_tail_cnt", 32'(bus_a.evt_count), 32'd1);
    pop_both();
    chk("t5_drained",  32'(bus_a.evt_valid), 32'd0);
    chk("t5_sticky",   32'(bus_a.overflow),  32'd1);

    // Pause sequence, then reset mid-way through a second one
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0);
    chk("t6_partial", 32'(bus_a.evt_count), 32'd0);
    send(8'h77);
    chk("t6_count",   32'(bus_a.evt_count), 32'd1);
    chk("t6_head",    32'(bus_a.evt_data),  32'h0E1);
    send(8'h58);
    send(8'hE1); send(8'h14); send(8'h77);
    chk("t6_mid",     32'(bus_a.evt_count), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_r_valid", 32'(bus_a.evt_valid), 32'd0);
    chk("t6_r_count", 32'(bus_a.evt_count), 32'd0);
    chk("t6_r_ovf",   32'(bus_a.overflow),  32'd0);
    chk("t6_r_caps",  32'(bus_a.caps_lock), 32'd0);
    chk("t6_r_data",  32'(bus_a.evt_data),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    send(8'h1C);
    chk("t6_post_a",  32'(bus_a.evt_data),  32'h01C);
    chk("t6_post_cnt",32'(bus_a.evt_count), 32'd1);
    chk("t6_post_b",  32'(bus_b.evt_data),  32'h01C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
